// File: rtl/z_writeback_sequencer.sv
// Captures a 64-bit ALU result into the Z pair and writes it back over the
// 32-bit shared bus: one beat to a GPR for narrow ops, LO then HI for wide ops.
module z_writeback_sequencer #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  localparam int DEST_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [2*DATA_W-1:0] res_data,
  input  logic                res_wide,
  input  logic [DEST_W-1:0]   dest_idx,
  output logic                bus_req,
  input  logic                bus_grant,
  output logic [DATA_W-1:0]   bus_out,
  output logic [NREG-1:0]     r_in,
  output logic                lo_in,
  output logic                hi_in,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LO_BEAT = 2'd1,
    HI_BEAT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   z_hi, z_lo;
  logic                wide_q;
  logic [DEST_W-1:0]   dest_q;
  logic                capture;

  localparam logic [NREG-1:0] ONE_HOT_BASE = {{(NREG-1){1'b0}}, 1'b1};

  assign capture = (state == IDLE) && res_valid;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state  <= IDLE;
      z_hi   <= '0;
      z_lo   <= '0;
      wide_q <= 1'b0;
      dest_q <= '0;
    end else begin
      state <= state_next;
      // Z and the latched op attributes only change at capture, so the
      // upstream result may change freely once it has been accepted.
      if (capture) begin
        z_hi   <= res_data[2*DATA_W-1:DATA_W];
        z_lo   <= res_data[DATA_W-1:0];
        wide_q <= res_wide;
        dest_q <= dest_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (res_valid) state_next = LO_BEAT;
      LO_BEAT: if (bus_grant) state_next = wide_q ? HI_BEAT : DONE;
      HI_BEAT: if (bus_grant) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs from state; write enables additionally need the grant.
  always_comb begin
    res_ready = 1'b0;
    bus_req   = 1'b0;
    bus_out   = '0;
    r_in      = '0;
    lo_in     = 1'b0;
    hi_in     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        res_ready = 1'b1;
        busy      = 1'b0;
      end
      LO_BEAT: begin
        bus_req = 1'b1;
        bus_out = z_lo;
        if (bus_grant) begin
          if (wide_q) lo_in = 1'b1;
          else        r_in  = ONE_HOT_BASE << dest_q;
        end
      end
      HI_BEAT: begin
        bus_req = 1'b1;
        bus_out = z_hi;
        hi_in   = bus_grant;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_z_writeback_sequencer.sv
// Directed and randomised checks of z_writeback_sequencer with immediate
// assertions; inputs change 2ns after each rising edge, checks 1ns later.
module tb_z_writeback_sequencer;

  localparam int DATA_W = 32;
  localparam int NREG   = 16;
  localparam int DEST_W = 4;

  logic                clock = 1'b0;
  logic                clear_n = 1'b0;
  logic                res_valid = 1'b0;
  logic                res_ready;
  logic [2*DATA_W-1:0] res_data = '0;
  logic                res_wide = 1'b0;
  logic [DEST_W-1:0]   dest_idx = '0;
  logic                bus_req;
  logic                bus_grant = 1'b0;
  logic [DATA_W-1:0]   bus_out;
  logic [NREG-1:0]     r_in;
  logic                lo_in;
  logic                hi_in;
  logic                busy;
  logic                done;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int hi_count = 0;

  z_writeback_sequencer #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clock(clock), .clear_n(clear_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_wide(res_wide), .dest_idx(dest_idx),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_out(bus_out),
    .r_in(r_in), .lo_in(lo_in), .hi_in(hi_in), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (done)  done_count++;
    if (hi_in) hi_count++;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [63:0] data,
                                input logic wide, input logic [3:0] dest,
                                input logic grant, input logic clr_n);
    res_valid = valid;
    res_data  = data;
    res_wide  = wide;
    dest_idx  = dest;
    bus_grant = grant;
    clear_n   = clr_n;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int d0;
    int h0;
    int accepted;
    int exp_done;
    logic [31:0] exp_lo, exp_hi;
    logic        exp_wide;
    logic [3:0]  exp_dest;
    logic [63:0] rnd;

    // Reset
    apply_stimulus(0, 64'h0, 0, 0, 0, 0);
    tick(); tick();
    apply_stimulus(0, 64'h0, 0, 0, 0, 1);
    check_output("rst_ready", res_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_req", bus_req, 0);
    check_output("rst_bus", bus_out, 0);
    check_output("rst_done", done, 0);
    check_output("rst_we", {r_in, lo_in, hi_in}, 0);

    // Narrow ADD to r5
    apply_stimulus(1, 64'h11, 0, 5, 1, 1);
    tick();
    apply_stimulus(0, 64'h0, 0, 0, 1, 1);
    check_output("nar_req", bus_req, 1);
    check_output("nar_bus", bus_out, 32'h11);
    check_output("nar_rin", r_in, 16'h0020);
    check_output("nar_lo", lo_in, 0);
    check_output("nar_busy", busy, 1);
    tick();
    check_output("nar_done", done, 1);
    check_output("nar_done_rin", r_in, 0);
    check_output("nar_done_req", bus_req, 0);
    check_output("nar_done_ready", res_ready, 0);
    tick();
    check_output("nar_ready", res_ready, 1);
    check_output("nar_idle_done", done, 0);

    // Wide MUL of -2
    apply_stimulus(1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 3, 1, 1);
    tick();
    apply_stimulus(0, 64'h0, 0, 0, 1, 1);
    check_output("mul_lo_in", lo_in, 1);
    check_output("mul_lo_bus", bus_out, 32'hFFFF_FFFE);
    check_output("mul_lo_rin", r_in, 0);
    check_output("mul_lo_hi", hi_in, 0);
    tick();
    check_output("mul_hi_in", hi_in, 1);
    check_output("mul_hi_bus", bus_out, 32'hFFFF_FFFF);
    check_output("mul_hi_lo", lo_in, 0);
    check_output("mul_hi_rin", r_in, 0);
    tick();
    check_output("mul_done", done, 1);
    check_output("mul_done_we", {r_in, lo_in, hi_in}, 0);
    tick();
    check_output("mul_ready", res_ready, 1);

    // Grant stall on a narrow write to r15
    d0 = done_count;
    apply_stimulus(1, 64'h1234_5678_0000_00AB, 0, 15, 0, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 64'h0, 0, 0, 0, 1);
      check_output("stall_req", bus_req, 1);
      check_output("stall_bus", bus_out, 32'hAB);
      check_output("stall_rin", r_in, 0);
      tick();
    end
    apply_stimulus(0, 64'h0, 0, 0, 1, 1);
    check_output("stall_write", r_in, 16'h8000);
    tick();
    check_output("stall_done", done, 1);
    tick();
    check_output("stall_idle", done, 0);
    check_output("stall_done_cnt", done_count - d0, 1);

    // Back-pressure: second value held on res_valid while busy
    apply_stimulus(1, 64'h55, 0, 2, 1, 1);
    tick();
    apply_stimulus(1, 64'h7, 0, 9, 1, 1);
    check_output("bp_ready_busy", res_ready, 0);
    check_output("bp_first_bus", bus_out, 32'h55);
    check_output("bp_first_rin", r_in, 16'h0004);
    tick();
    apply_stimulus(1, 64'h7, 0, 9, 1, 1);
    check_output("bp_done", done, 1);
    check_output("bp_done_ready", res_ready, 0);
    tick();
    apply_stimulus(1, 64'h7, 0, 9, 1, 1);
    check_output("bp_idle_ready", res_ready, 1);
    tick();
    apply_stimulus(0, 64'h0, 0, 0, 1, 1);
    check_output("bp_second_bus", bus_out, 32'h7);
    check_output("bp_second_rin", r_in, 16'h0200);
    tick(); tick();
    check_output("bp_end_ready", res_ready, 1);

    // Reset between the LO and HI beats of a wide op
    d0 = done_count;
    h0 = hi_count;
    apply_stimulus(1, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 1, 1);
    tick();
    apply_stimulus(0, 64'h0, 0, 0, 1, 1);
    check_output("rmid_lo_in", lo_in, 1);
    check_output("rmid_lo_bus", bus_out, 32'hCCCC_DDDD);
    tick();
    apply_stimulus(0, 64'h0, 0, 0, 0, 0);
    check_output("rmid_hi_bus", bus_out, 32'hAAAA_BBBB);
    check_output("rmid_hi_in", hi_in, 0);
    tick();
    apply_stimulus(0, 64'h0, 0, 0, 1, 1);
    check_output("rmid_ready", res_ready, 1);
    check_output("rmid_busy", busy, 0);
    check_output("rmid_bus", bus_out, 0);
    check_output("rmid_we", {r_in, lo_in, hi_in}, 0);
    check_output("rmid_done", done, 0);
    tick();
    check_output("rmid_hi_cnt", hi_count - h0, 0);
    check_output("rmid_done_cnt", done_count - d0, 0);

    // Random sweep
    d0 = done_count;
    accepted = 0;
    exp_lo = '0; exp_hi = '0; exp_wide = 1'b0; exp_dest = '0;
    for (int c = 0; c < 1000; c++) begin
      rnd = {$urandom, $urandom};
      apply_stimulus(($urandom_range(0, 2) != 0), rnd, $urandom_range(0, 1),
                     4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1);
      check_output("sw_excl", 64'($countones(r_in) + lo_in + hi_in <= 1), 1);
      check_output("sw_we_gate",
                   64'(((r_in != 0) || lo_in || hi_in) && !(bus_req && bus_grant)), 0);
      check_output("sw_bus_zero", 64'(!bus_req && (bus_out != 0)), 0);
      if (r_in != 0) begin
        check_output("sw_rin_dest", r_in, 16'h1 << exp_dest);
        check_output("sw_rin_data", bus_out, exp_lo);
        check_output("sw_rin_narrow", exp_wide, 0);
      end
      if (lo_in) check_output("sw_lo_data", bus_out, exp_lo);
      if (hi_in) check_output("sw_hi_data", bus_out, exp_hi);
      if (res_valid && res_ready) begin
        accepted++;
        exp_lo   = res_data[31:0];
        exp_hi   = res_data[63:32];
        exp_wide = res_wide;
        exp_dest = dest_idx;
      end
      tick();
    end
    apply_stimulus(0, 64'h0, 0, 0, 1, 1);
    for (int c = 0; c < 5; c++) tick();
    exp_done = accepted;
    check_output("sw_done_cnt", done_count - d0, exp_done);
    check_output("sw_end_idle", res_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
